// File: rtl/processor_control_unit.sv
// Control FSM for a simple bus-based processor: decodes IR into per-cycle
// register/ALU/bus enables over the T0..T3 instruction phases.
module processor_control_unit #(
   parameter int dataWidth = 9
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [dataWidth-1:0] DataAndInstructionInput,
   input  logic                 Run,
   output logic                 IRin,
   output logic [7:0]           Rin,
   output logic [7:0]           Rout,
   output logic                 Ain,
   output logic                 Gin,
   output logic                 Gout,
   output logic                 DINout,
   output logic                 AddSub,
   output logic                 Done,
   output logic                 Busy,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [dataWidth-1:0] ir_q, ir_d;
   logic [2:0]           opcode, reg_x, reg_y;

   assign opcode = ir_q[8:6];
   assign reg_x  = ir_q[5:3];
   assign reg_y  = ir_q[2:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      IRin    = 1'b0;
      Rin     = 8'd0;
      Rout    = 8'd0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      DINout  = 1'b0;
      AddSub  = 1'b0;
      Done    = 1'b0;
      Busy    = 1'b0;
      state   = 2'd0;
      // Reset blanks every output combinationally, so an aborted instruction
      // never emits a write or Done pulse.
      if (!reset) begin
         state = state_q;
         Busy  = (state_q != T0);
         case (state_q)
            T0: begin
               IRin = Run;
               if (Run) begin
                  ir_d    = DataAndInstructionInput;
                  state_d = T1;
               end
            end
            T1: begin
               case (opcode)
                  3'b000: begin
                     Rout[reg_y] = 1'b1;
                     Rin[reg_x]  = 1'b1;
                     Done        = 1'b1;
                     state_d     = T0;
                  end
                  3'b001: begin
                     DINout      = 1'b1;
                     Rin[reg_x]  = 1'b1;
                     Done        = 1'b1;
                     state_d     = T0;
                  end
                  3'b010, 3'b011: begin
                     Rout[reg_x] = 1'b1;
                     Ain         = 1'b1;
                     state_d     = T2;
                  end
                  default: begin
                     Done    = 1'b1;
                     state_d = T0;
                  end
               endcase
            end
            T2: begin
               Rout[reg_y] = 1'b1;
               Gin         = 1'b1;
               AddSub      = ir_q[6];
               state_d     = T3;
            end
            T3: begin
               Gout       = 1'b1;
               Rin[reg_x] = 1'b1;
               Done       = 1'b1;
               state_d    = T0;
            end
            default: state_d = T0;
         endcase
      end
   end

endmodule

// File: tb/tb_processor_control_unit.sv
// Randomized and directed bench for processor_control_unit against an
// instruction-level reference model (current instruction + phase number).
module tb_processor_control_unit;

   logic       clock;
   logic       reset;
   logic [8:0] din;
   logic       run;
   logic       IRin, Ain, Gin, Gout, DINout, AddSub, Done, Busy;
   logic [7:0] Rin, Rout;
   logic [1:0] state;

   int total_checks = 0;
   int passed_checks = 0;

   // reference model: phase 0 = waiting for Run, 1..n = step within instruction
   int         m_phase = 0;
   logic [8:0] m_ir = 9'd0;

   processor_control_unit #(.dataWidth(9)) dut (
      .clock(clock),
      .reset(reset),
      .DataAndInstructionInput(din),
      .Run(run),
      .IRin(IRin),
      .Rin(Rin),
      .Rout(Rout),
      .Ain(Ain),
      .Gin(Gin),
      .Gout(Gout),
      .DINout(DINout),
      .AddSub(AddSub),
      .Done(Done),
      .Busy(Busy),
      .state(state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [25:0] got, input logic [25:0] exp);
      total_checks++;
      if (got === exp) passed_checks++;
      else $display("FAIL %s: got %07h expected %07h", tag, got, exp);
   endtask

   function automatic int instr_len(input logic [8:0] ir);
      return (ir[8:6] == 3'b010 || ir[8:6] == 3'b011) ? 3 : 1;
   endfunction

   // Expected outputs packed as {IRin,Rin,Rout,Ain,Gin,Gout,DINout,AddSub,Done,Busy,state}
   function automatic logic [25:0] expected(input int ph, input logic [8:0] ir,
                                            input logic r, input logic rst);
      logic       e_irin, e_ain, e_gin, e_gout, e_din, e_as, e_done;
      logic [7:0] e_rin, e_rout;
      int         x, y;
      e_irin = 0; e_ain = 0; e_gin = 0; e_gout = 0; e_din = 0; e_as = 0; e_done = 0;
      e_rin = 0; e_rout = 0;
      x = int'(ir[5:3]);
      y = int'(ir[2:0]);
      if (rst) return 26'd0;
      if (ph == 0) e_irin = r;
      else begin
         unique case (ir[8:6])
            3'b000: begin e_rout[y] = 1; e_rin[x] = 1; e_done = 1; end
            3'b001: begin e_din = 1; e_rin[x] = 1; e_done = 1; end
            3'b010, 3'b011: begin
               if (ph == 1) begin e_rout[x] = 1; e_ain = 1; end
               else if (ph == 2) begin e_rout[y] = 1; e_gin = 1; e_as = (ir[8:6] == 3'b011); end
               else begin e_gout = 1; e_rin[x] = 1; e_done = 1; end
            end
            default: e_done = 1;
         endcase
      end
      return {e_irin, e_rin, e_rout, e_ain, e_gin, e_gout, e_din, e_as, e_done,
              (ph != 0), 2'(ph)};
   endfunction

   task automatic cyc(input string tag, input logic rst, input logic r, input logic [8:0] d);
      logic [25:0] got;
      reset = rst;
      run   = r;
      din   = d;
      #1;
      got = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Busy, state};
      check_eq(tag, got, expected(m_phase, m_ir, r, rst));
      check_eq({tag, "_bus"}, 26'($countones({Rout, Gout, DINout}) <= 1), 26'd1);
      @(posedge clock);
      if (rst) begin
         m_phase = 0;
         m_ir    = 9'd0;
      end else if (m_phase == 0) begin
         if (r) begin
            m_ir    = d;
            m_phase = 1;
         end
      end else if (m_phase >= instr_len(m_ir)) m_phase = 0;
      else m_phase++;
      #1;
   endtask

   initial begin
      reset = 1'b1;
      run   = 1'b0;
      din   = 9'd0;
      cyc("reset0", 1, 1, 9'b001_010_000);
      cyc("reset1", 1, 0, 9'd0);
      // movi R2
      cyc("movi_t0", 0, 1, 9'b001_010_000);
      cyc("movi_t1", 0, 0, 9'd0);
      cyc("movi_idle", 0, 0, 9'd0);
      // mov R1,R2
      cyc("mov_t0", 0, 1, 9'b000_001_010);
      cyc("mov_t1", 0, 0, 9'd0);
      // sub R5,R6 with Run toggling during the instruction
      cyc("sub_t0", 0, 1, 9'b011_101_110);
      cyc("sub_t1", 0, 1, 9'b001_111_000);
      cyc("sub_t2", 0, 0, 9'd0);
      cyc("sub_t3", 0, 1, 9'b001_111_000);
      cyc("sub_idle", 0, 0, 9'd0);
      // add aborted by reset in T2
      cyc("abort_t0", 0, 1, 9'b010_011_100);
      cyc("abort_t1", 0, 0, 9'd0);
      cyc("abort_rst", 1, 1, 9'd0);
      cyc("abort_after", 0, 0, 9'd0);
      cyc("abort_after2", 0, 0, 9'd0);
      // back-to-back movi with Run held high
      for (int i = 0; i < 5; i++) cyc("b2b", 0, 1, 9'b001_000_000 | 9'(i << 3));
      // NOP opcode and mov R3,R3
      cyc("nop_t0", 0, 1, 9'b111_000_000);
      cyc("nop_t1", 0, 1, 9'b000_011_011);
      cyc("movxx_t1", 0, 0, 9'd0);
      cyc("movxx_idle", 0, 0, 9'd0);
      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++)
         cyc("rand", ($urandom_range(0, 24) == 0), 1'($urandom), 9'($urandom));
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/processor_control_unit.md
PROCESSOR_CONTROL_UNIT -- requirements
Module: processor_control_unit

Interface
REQ-001 The block SHALL have parameter dataWidth, default 9, giving the instruction word width; the fields are IR[8:6]=opcode, IR[5:3]=X, IR[2:0]=Y, and dataWidth SHALL be at least 9.
REQ-002 The block SHALL have port clock, input, 1 bit; it is the single clock, and all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port DataAndInstructionInput, input, dataWidth bits; it carries the instruction word, captured into IR.
REQ-005 The block SHALL have port Run, input, 1 bit; it starts an instruction fetch when the FSM is in T0.
REQ-006 The block SHALL have port IRin, output, 1 bit; it is the IR load strobe.
REQ-007 The block SHALL have port Rin, output, 8 bits; bit i is the write enable of register i.
REQ-008 The block SHALL have port Rout, output, 8 bits; bit i drives register i onto BusWires.
REQ-009 The block SHALL have ports Ain, Gin, Gout and DINout, each output, 1 bit; these are the A load, G load, G-to-bus and DIN-to-bus enables.
REQ-010 The block SHALL have port AddSub, output, 1 bit; 0 means add and 1 means subtract.
REQ-011 The block SHALL have ports Done and Busy, each output, 1 bit; Done marks the final cycle of an instruction, and Busy is high when the state is not T0.
REQ-012 The block SHALL have port state, output, 2 bits; it encodes T0=0, T1=1, T2=2, T3=3 for debug.

Function
REQ-013 The block SHALL hold a dataWidth-bit IR register and a 2-bit state register (T0..T3).
REQ-014 In T0, IRin SHALL equal Run; if Run=1, IR SHALL load DataAndInstructionInput at the clock edge and the FSM SHALL go to T1; otherwise it SHALL stay in T0.
REQ-015 Opcode 000 (mov), in T1: Rout[Y]=1, Rin[X]=1, Done=1, then the FSM SHALL return to T0.
REQ-016 Opcode 001 (movi), in T1: DINout=1, Rin[X]=1, Done=1, then the FSM SHALL return to T0.
REQ-017 Opcodes 010 (add) and 011 (sub), in T1: Rout[X]=1, Ain=1, then the FSM SHALL go to T2.
REQ-018 Opcodes 010 and 011, in T2: Rout[Y]=1, Gin=1, AddSub=IR[6], then the FSM SHALL go to T3.
REQ-019 Opcodes 010 and 011, in T3: Gout=1, Rin[X]=1, Done=1, then the FSM SHALL return to T0.
REQ-020 Opcodes 100-111 SHALL act as a NOP: in T1 only Done=1, then the FSM SHALL return to T0.
REQ-021 Every output not asserted by REQ-014..020 SHALL be 0 in that state.
REQ-022 At most one of {Rout bits, Gout, DINout} SHALL be 1 in any cycle, so the bus has a single driver.
REQ-023 All outputs SHALL be combinational functions of state, IR and Run, with no added latency; instruction latency SHALL be 2 cycles for mov, movi and NOP, and 4 cycles for add and sub, counted from the Run-sampled edge through the Done cycle.
REQ-024 Run SHALL be ignored in T1, T2 and T3, and IR SHALL NOT change outside T0.
REQ-025 X=Y SHALL be legal: mov R3,R3 asserts Rout[3] and Rin[3] together.
REQ-026 After Done, Run=1 in the next T0 cycle SHALL start the next fetch immediately, with no idle cycle required.

Reset
REQ-027 While reset=1 at a clock edge, state SHALL become T0 and IR SHALL become 0.
REQ-028 While reset=1, all outputs SHALL be forced to 0, including IRin, regardless of Run.
REQ-029 Reset asserted in T1, T2 or T3 SHALL abort the instruction: no Rin or Done pulse SHALL follow, and the first cycle after reset is released SHALL be T0.
REQ-030 Reset SHALL take priority over Run in the same cycle.

Verification
REQ-031 The bench SHALL check: reset, then Run=1 with DataAndInstructionInput=9'b001_010_000 (movi R2) -> next cycle T1 with DINout=1, Rin=8'b0000_0100, Done=1, then T0.
REQ-032 The bench SHALL check: 9'b000_001_010 (mov R1,R2) -> T1 with Rout=8'b0000_0100, Rin=8'b0000_0010, Done=1, all other outputs 0.
REQ-033 The bench SHALL check: 9'b011_101_110 (sub R5,R6) -> T1 Rout[5] with Ain; T2 Rout[6] with Gin and AddSub=1; T3 Gout with Rin[5] and Done; Busy=1 in T1..T3.
REQ-034 The bench SHALL check: add in progress with reset=1 during T2 -> next cycle T0 with all outputs 0, and no Rin[X] or Done pulse ever appears.
REQ-035 The bench SHALL check: Run held at 1 across two back-to-back movi instructions -> the second IRin occurs in the cycle immediately after the first Done, and Run toggling in T1 has no effect.
REQ-036 The bench SHALL check: opcode 9'b111_000_000 -> T1 with Done=1 only, every enable 0, then return to T0.
